pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard, forwarding and stall controller for the 5-stage MIPS pipeline. It generalises the forwarding/stall logic to `FWD_DEPTH` forwarding stages and configurable load latency. It adds a counter-based branch-flush sequencer and a memory-wait FSM with timeout. It sits beside the instruction decoder in ID and drives the enable/reset pins of every stage register.

## Interface
- `REG_AW`, 5, register address width
- `FWD_DEPTH`, 2, number of post-ID stages that can forward (index 0 = EXE, 1 = MEM, ...)
- `LOAD_READY`, 1, first stage index whose load data is forwardable
- `BRANCH_FLUSH`, 3, total cycles `id_flush` is held per branch (≥1)
- `MEM_TIMEOUT`, 15, wait cycles before memory error (≥1)

- `clk` input 1: main clock
- `rst` input 1: asynchronous, active-low reset
- `rs_addr`, `rt_addr` input REG_AW each: ID source addresses
- `rs_used`, `rt_used` input 1 each: ID reads rs / rt
- `id_is_store` input 1: ID holds SW
- `id_is_branch` input 1: ID holds a jump/branch
- `stg_waddr` input FWD_DEPTH*REG_AW: write address per stage, stage i at bits [i*REG_AW +: REG_AW]
- `stg_wen` input FWD_DEPTH: write enable per stage
- `stg_load` input FWD_DEPTH: stage holds a load
- `mem_req` input 1: MEM stage access pending (level)
- `mem_ack` input 1: memory completes this cycle
- `debug_en`, `debug_step` input 1 each: single-step control
- `fwd_a_sel`, `fwd_b_sel` output $clog2(FWD_DEPTH+1): 0 = register file, i+1 = forward from stage i
- `store_fwd` output 1: forward load data into SW data path in MEM
- `id_flush` output 1: branch flush in progress
- `mem_err` output 1: sticky memory timeout flag
- `stage_en` output 5: enable per stage, IF=0 … WB=4
- `stage_rst` output 5: synchronous bubble insert per stage

## Operation
- Forwarding, per operand, when used and address ≠ 0: pick the lowest stage index i with `stg_wen[i]` and a matching address. Select is i+1 unless `stg_load[i]` and i < LOAD_READY, which is a load-use hazard. No match gives 0.
- Load-use hazard: `load_stall`=1, except the store case in Configuration.
- Branch sequencer: 2-bit+ counter `bcnt`.
  - `id_flush` = (`id_is_branch` & `stage_en[1]`) | (`bcnt`≠0).
  - Branch accepted (`id_is_branch` & `stage_en[1]`) loads `bcnt` = BRANCH_FLUSH−1.
  - Otherwise `bcnt` decrements when `stage_en[2]` and is nonzero.
- Memory FSM states:
  - IDLE: on `mem_req` & ~`mem_ack` go to WAIT, `wcnt`=1.
  - WAIT: `mem_ack` goes to IDLE. `wcnt`==MEM_TIMEOUT goes to ERR. Otherwise `wcnt`++.
  - ERR: terminal until reset. `mem_err`=1.
- `mem_stall` = (`mem_req` & ~`mem_ack`) in IDLE/WAIT.
- Debug: register `debug_step` into `step_prev`. `dbg_hold` = `debug_en` & ~(`debug_step` & ~`step_prev`).
- Stage control defaults: all en=1, all rst=0. First match in this priority:
  1. ERR: en=0 for all stages.
  2. `mem_stall`: en[3:0]=0, rst[4]=1.
  3. `dbg_hold`: en=0 for all stages.
  4. `load_stall`: en[1:0]=0, rst[2]=1.
  5. `id_flush`: rst[1]=1.
- Forward selects are meaningful only when `load_stall`=0.

## Timing
- Forward selects, stalls and stage controls are combinational from inputs and registered state, valid in the same cycle.
- `mem_ack` in the same cycle as a new `mem_req` gives no stall and no FSM transition.
- Pipeline resumes in the cycle `mem_ack` is seen.
- ERR is entered MEM_TIMEOUT+1 cycles after the first unacked `mem_req`.
- Simultaneous branch acceptance and nonzero `bcnt` reloads `bcnt`.
- While `rst` is low:
  - `bcnt`=0, `wcnt`=0, FSM=IDLE, `step_prev`=0, `mem_err`=0.
  - `stage_rst`=5'b11111, `stage_en`=5'b11111.
  - `fwd_*`=0, `store_fwd`=0, `id_flush`=0.
- Reset assertion mid-wait or mid-flush aborts immediately.

## Configuration
- `PIPE_STORE_FWD_EN` defined: a load-use hazard on rt only, with `id_is_store`=1 and the hazard at stage 0, gives `store_fwd`=1 and no stall. A hazard on rs still stalls.
- Undefined: `store_fwd` is tied 0 and every load-use hazard stalls.

## Test plan
- Stage 0 writes r3 (non-load), ID `add` reads r3 → `fwd_a_sel`=1, no stall.
- Both stages match r3 → `fwd_a_sel`=1. Stage 1 only → 2.
- Stage 0 load r5, ID reads r5 → `stage_en`=5'b11100, `stage_rst[2]`=1 for one cycle. Next cycle (load now in stage 1) → `fwd_a_sel`=2.
- Store-forward case: stage 0 load r5, ID `sw` with rt=r5. With `PIPE_STORE_FWD_EN` → `store_fwd`=1, no stall. Without it → stall.
- Branch accepted in ID, BRANCH_FLUSH=3 → `id_flush` high 3 consecutive advancing cycles. A `mem_stall` inserted mid-sequence extends it by the frozen cycles.
- `mem_req` held and `mem_ack` given after 4 cycles → `stage_en[3:0]`=0 for 4 cycles, then resume. `mem_req` never acked, MEM_TIMEOUT=15 → `mem_err`=1 in cycle 16 and all `stage_en`=0 until `rst` low.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall controller for the 5-stage pipeline: forward selects, load-use stall, branch flush, memory wait/timeout.
// Combinational outputs, same cycle; optional `PIPE_STORE_FWD_EN` lets a store take load data in MEM instead of stalling.
module pipe_hazard_ctrl #(
   parameter int REG_AW       = 5,
   parameter int FWD_DEPTH    = 2,
   parameter int LOAD_READY   = 1,
   parameter int BRANCH_FLUSH = 3,
   parameter int MEM_TIMEOUT  = 15
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [REG_AW-1:0]                 rs_addr,
   input  logic [REG_AW-1:0]                 rt_addr,
   input  logic                              rs_used,
   input  logic                              rt_used,
   input  logic                              id_is_store,
   input  logic                              id_is_branch,
   input  logic [FWD_DEPTH*REG_AW-1:0]       stg_waddr,
   input  logic [FWD_DEPTH-1:0]              stg_wen,
   input  logic [FWD_DEPTH-1:0]              stg_load,
   input  logic                              mem_req,
   input  logic                              mem_ack,
   input  logic                              debug_en,
   input  logic                              debug_step,
   output logic [$clog2(FWD_DEPTH+1)-1:0]    fwd_a_sel,
   output logic [$clog2(FWD_DEPTH+1)-1:0]    fwd_b_sel,
   output logic                              store_fwd,
   output logic                              id_flush,
   output logic                              mem_err,
   output logic [4:0]                        stage_en,
   output logic [4:0]                        stage_rst
);

   localparam int SELW = $clog2(FWD_DEPTH + 1);
   localparam int BCW  = ($clog2(BRANCH_FLUSH) < 2) ? 2 : $clog2(BRANCH_FLUSH);
   localparam int WCW  = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ERR  = 2'd2
   } mem_state_t;

   typedef struct packed {
      logic            haz;
      logic            stg0;
      logic [SELW-1:0] sel;
   } lookup_t;

   // Lowest matching stage wins: scan from the top so earlier stages overwrite.
   function automatic lookup_t fwd_lookup(
      input logic [REG_AW-1:0]           addr,
      input logic                        used,
      input logic [FWD_DEPTH*REG_AW-1:0] waddr,
      input logic [FWD_DEPTH-1:0]        wen,
      input logic [FWD_DEPTH-1:0]        ld
   );
      lookup_t r;
      r = '0;
      if (used && (addr != '0)) begin
         for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
            if (wen[i] && (waddr[i*REG_AW +: REG_AW] == addr)) begin
               r.stg0 = (i == 0);
               r.haz  = ld[i] && (i < LOAD_READY);
               r.sel  = SELW'(i + 1);
            end
         end
         if (r.haz) r.sel = '0;
      end
      return r;
   endfunction

   mem_state_t     r_state;
   mem_state_t     w_state_nxt;
   logic [WCW-1:0] r_wcnt;
   logic [WCW-1:0] w_wcnt_nxt;
   logic [BCW-1:0] r_bcnt;
   logic           r_step_prev;

   lookup_t        w_lk_a;
   lookup_t        w_lk_b;
   logic           w_store_fwd;
   logic           w_load_stall;
   logic           w_mem_stall;
   logic           w_err;
   logic           w_dbg_hold;
   logic           w_take_br;
   logic           w_id_flush;
   logic [4:0]     w_en;
   logic [4:0]     w_srst;

   always_comb begin
      w_lk_a = fwd_lookup(rs_addr, rs_used, stg_waddr, stg_wen, stg_load);
      w_lk_b = fwd_lookup(rt_addr, rt_used, stg_waddr, stg_wen, stg_load);
   end

`ifdef PIPE_STORE_FWD_EN
   // A SW only needs rt in MEM, so a stage-0 load can feed it there without a bubble.
   assign w_store_fwd = w_lk_b.haz & ~w_lk_a.haz & id_is_store & w_lk_b.stg0;
`else
   logic w_unused_store;
   assign w_unused_store = id_is_store;
   assign w_store_fwd    = 1'b0;
`endif

   assign w_load_stall = w_lk_a.haz | (w_lk_b.haz & ~w_store_fwd);
   assign w_err        = (r_state == S_ERR);
   assign w_dbg_hold   = debug_en & ~(debug_step & ~r_step_prev);

   always_comb begin
      w_state_nxt = r_state;
      w_wcnt_nxt  = r_wcnt;
      w_mem_stall = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_mem_stall = mem_req & ~mem_ack;
            if (mem_req && !mem_ack) begin
               w_state_nxt = S_WAIT;
               w_wcnt_nxt  = WCW'(1);
            end
         end
         S_WAIT: begin
            w_mem_stall = mem_req & ~mem_ack;
            if (mem_ack) begin
               w_state_nxt = S_IDLE;
               w_wcnt_nxt  = '0;
            end else if (r_wcnt == WCW'(MEM_TIMEOUT)) begin
               w_state_nxt = S_ERR;
            end else begin
               w_wcnt_nxt = r_wcnt + WCW'(1);
            end
         end
         S_ERR: begin
            w_state_nxt = S_ERR;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_wcnt_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_wcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_wcnt  <= w_wcnt_nxt;
      end
   end

   always_comb begin
      w_en = 5'b11111;
      if (w_err)             w_en = 5'b00000;
      else if (w_mem_stall)  w_en = 5'b10000;
      else if (w_dbg_hold)   w_en = 5'b00000;
      else if (w_load_stall) w_en = 5'b11100;
   end

   assign w_take_br  = id_is_branch & w_en[1];
   assign w_id_flush = w_take_br | (r_bcnt != '0);

   always_comb begin
      w_srst = 5'b00000;
      if (!w_err) begin
         if (w_mem_stall) begin
            w_srst = 5'b10000;
         end else if (!w_dbg_hold) begin
            if (w_load_stall)    w_srst = 5'b00100;
            else if (w_id_flush) w_srst = 5'b00010;
         end
      end
   end

   // Flush count only advances when EXE moves, so frozen cycles stretch the flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bcnt <= '0;
      end else if (w_take_br) begin
         r_bcnt <= BCW'(BRANCH_FLUSH - 1);
      end else if (w_en[2] && (r_bcnt != '0)) begin
         r_bcnt <= r_bcnt - BCW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_step_prev <= 1'b0;
      else      r_step_prev <= debug_step;
   end

   assign fwd_a_sel = rst ? w_lk_a.sel  : '0;
   assign fwd_b_sel = rst ? w_lk_b.sel  : '0;
   assign store_fwd = rst & w_store_fwd;
   assign id_flush  = rst & w_id_flush;
   assign mem_err   = w_err;
   assign stage_en  = rst ? w_en   : 5'b11111;
   assign stage_rst = rst ? w_srst : 5'b11111;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

   localparam int REG_AW = 5;
   localparam int FD     = 2;
   localparam int LR     = 1;
   localparam int BF     = 3;
   localparam int MT     = 15;
   localparam int SELW   = $clog2(FD + 1);

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [REG_AW-1:0]    rs_addr, rt_addr;
   logic                 rs_used, rt_used, id_is_store, id_is_branch;
   logic [FD*REG_AW-1:0] stg_waddr;
   logic [FD-1:0]        stg_wen, stg_load;
   logic                 mem_req, mem_ack, debug_en, debug_step;
   logic [SELW-1:0]      fwd_a_sel, fwd_b_sel;
   logic                 store_fwd, id_flush, mem_err;
   logic [4:0]           stage_en, stage_rst;

   int checks = 0;
   int errors = 0;

   pipe_hazard_ctrl #(
      .REG_AW(REG_AW), .FWD_DEPTH(FD), .LOAD_READY(LR), .BRANCH_FLUSH(BF), .MEM_TIMEOUT(MT)
   ) dut (
      .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
      .id_is_store(id_is_store), .id_is_branch(id_is_branch), .stg_waddr(stg_waddr), .stg_wen(stg_wen),
      .stg_load(stg_load), .mem_req(mem_req), .mem_ack(mem_ack), .debug_en(debug_en), .debug_step(debug_step),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .store_fwd(store_fwd), .id_flush(id_flush),
      .mem_err(mem_err), .stage_en(stage_en), .stage_rst(stage_rst)
   );

   always #5 clk = ~clk;

   // Reference state: flush cycles still owed, cycles spent waiting on memory, timeout flag.
   int m_flush_left;
   int m_waited;
   bit m_err;
   bit m_step_prev;

   typedef struct packed {
      logic [SELW-1:0] sel_a;
      logic [SELW-1:0] sel_b;
      logic            sfwd;
      logic            stall;
      logic            flush;
      logic            err;
      logic [4:0]      en;
      logic [4:0]      rs;
   } exp_t;

   function automatic void fwd_ref(input logic [REG_AW-1:0] addr, input logic used,
                                   output int sel, output bit haz, output int stg);
      sel = 0; haz = 0; stg = -1;
      if (used && addr != 0) begin
         for (int i = 0; i < FD; i++) begin
            if (stg_wen[i] && stg_waddr[i*REG_AW +: REG_AW] == addr) begin
               stg = i;
               if (stg_load[i] && i < LR) haz = 1;
               else sel = i + 1;
               break;
            end
         end
      end
   endfunction

   function automatic exp_t model_exp();
      exp_t e;
      int sa, sb, ga, gb;
      bit ha, hb, mstall, dbg;
      fwd_ref(rs_addr, rs_used, sa, ha, ga);
      fwd_ref(rt_addr, rt_used, sb, hb, gb);
      e = '0;
`ifdef PIPE_STORE_FWD_EN
      e.sfwd = hb && !ha && id_is_store && gb == 0;
`endif
      e.stall = ha || (hb && !e.sfwd);
      e.sel_a = SELW'(sa);
      e.sel_b = SELW'(sb);
      mstall  = !m_err && mem_req && !mem_ack;
      dbg     = debug_en && !(debug_step && !m_step_prev);
      e.en    = 5'b11111;
      e.rs    = 5'b00000;
      if (m_err)        e.en = 5'b00000;
      else if (mstall)  begin e.en = 5'b10000; e.rs = 5'b10000; end
      else if (dbg)     e.en = 5'b00000;
      else if (e.stall) begin e.en = 5'b11100; e.rs = 5'b00100; end
      e.flush = (id_is_branch && e.en[1]) || m_flush_left > 0;
      if (!m_err && !mstall && !dbg && !e.stall && e.flush) e.rs = 5'b00010;
      e.err = m_err;
      if (!rst) begin
         e.sel_a = 0; e.sel_b = 0; e.sfwd = 0; e.flush = 0; e.err = 0;
         e.en = 5'b11111; e.rs = 5'b11111;
      end
      return e;
   endfunction

   function automatic int next_flush();
      exp_t e;
      e = model_exp();
      if (id_is_branch && e.en[1]) return BF - 1;
      if (e.en[2] && m_flush_left > 0) return m_flush_left - 1;
      return m_flush_left;
   endfunction

   function automatic int next_waited();
      if (m_err) return m_waited;
      if (m_waited == 0) return (mem_req && !mem_ack) ? 1 : 0;
      if (mem_ack) return 0;
      if (m_waited == MT) return m_waited;
      return m_waited + 1;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_flush_left <= 0; m_waited <= 0; m_err <= 0; m_step_prev <= 0;
      end else begin
         m_flush_left <= next_flush();
         m_waited     <= next_waited();
         m_err        <= m_err || (m_waited == MT && !mem_ack);
         m_step_prev  <= debug_step;
      end
   end

   task automatic idle();
      rs_addr = 0; rt_addr = 0; rs_used = 0; rt_used = 0; id_is_store = 0; id_is_branch = 0;
      stg_waddr = 0; stg_wen = 0; stg_load = 0; mem_req = 0; mem_ack = 0; debug_en = 0; debug_step = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      id_is_branch = 1; stg_wen = 2'b01; stg_waddr = {5'd0, 5'd3}; rs_addr = 3; rs_used = 1; mem_req = 1;
      #2;
      checks++; if (stage_en !== 5'b11111) begin errors++; $display("FAIL rst_en got=%b exp=11111", stage_en); end
      checks++; if (stage_rst !== 5'b11111) begin errors++; $display("FAIL rst_rst got=%b exp=11111", stage_rst); end
      checks++; if (fwd_a_sel !== 0) begin errors++; $display("FAIL rst_fwd got=%0d exp=0", fwd_a_sel); end
      checks++; if ({id_flush, mem_err, store_fwd} !== 3'b000) begin
         errors++; $display("FAIL rst_flags got=%b exp=000", {id_flush, mem_err, store_fwd}); end
      next_cycle();
      rst = 1; idle();
   endtask

   task automatic test_forwarding();
      stg_wen = 2'b01; stg_waddr = {5'd0, 5'd3}; rs_addr = 3; rs_used = 1;
      @(negedge clk);
      checks++; if (fwd_a_sel !== 1) begin errors++; $display("FAIL fwd_s0 got=%0d exp=1", fwd_a_sel); end
      checks++; if ({stage_en, stage_rst} !== 10'b11111_00000) begin
         errors++; $display("FAIL fwd_nostall got=%b exp=1111100000", {stage_en, stage_rst}); end
      next_cycle();
      stg_wen = 2'b11; stg_waddr = {5'd3, 5'd3};
      @(negedge clk);
      checks++; if (fwd_a_sel !== 1) begin errors++; $display("FAIL fwd_both got=%0d exp=1", fwd_a_sel); end
      next_cycle();
      stg_wen = 2'b10; rt_addr = 3; rt_used = 1;
      @(negedge clk);
      checks++; if (fwd_a_sel !== 2) begin errors++; $display("FAIL fwd_s1 got=%0d exp=2", fwd_a_sel); end
      checks++; if (fwd_b_sel !== 2) begin errors++; $display("FAIL fwd_b_s1 got=%0d exp=2", fwd_b_sel); end
      next_cycle();
      stg_wen = 2'b11; stg_waddr = {5'd0, 5'd0}; rs_addr = 0; rt_used = 0;
      @(negedge clk);
      checks++; if (fwd_a_sel !== 0) begin errors++; $display("FAIL fwd_r0 got=%0d exp=0", fwd_a_sel); end
      next_cycle();
      stg_waddr = {5'd3, 5'd3}; rs_addr = 3; rs_used = 0;
      @(negedge clk);
      checks++; if (fwd_a_sel !== 0) begin errors++; $display("FAIL fwd_unused got=%0d exp=0", fwd_a_sel); end
      next_cycle();
      idle();
   endtask

   task automatic test_load_use();
      stg_wen = 2'b01; stg_load = 2'b01; stg_waddr = {5'd0, 5'd5}; rs_addr = 5; rs_used = 1;
      @(negedge clk);
      checks++; if ({stage_en, stage_rst} !== 10'b11100_00100) begin
         errors++; $display("FAIL lu_stall got=%b exp=1110000100", {stage_en, stage_rst}); end
      next_cycle();
      stg_wen = 2'b10; stg_load = 2'b10; stg_waddr = {5'd5, 5'd0};
      @(negedge clk);
      checks++; if (fwd_a_sel !== 2) begin errors++; $display("FAIL lu_fwd got=%0d exp=2", fwd_a_sel); end
      checks++; if (stage_en !== 5'b11111) begin errors++; $display("FAIL lu_resume got=%b exp=11111", stage_en); end
      next_cycle();
      idle();
      stg_wen = 2'b01; stg_load = 2'b01; stg_waddr = {5'd0, 5'd5}; rt_addr = 5; rt_used = 1; id_is_store = 1;
      @(negedge clk);
`ifdef PIPE_STORE_FWD_EN
      checks++; if ({store_fwd, stage_en} !== 6'b1_11111) begin
         errors++; $display("FAIL sw_fwd got=%b exp=111111", {store_fwd, stage_en}); end
`else
      checks++; if ({store_fwd, stage_en} !== 6'b0_11100) begin
         errors++; $display("FAIL sw_stall got=%b exp=011100", {store_fwd, stage_en}); end
`endif
      next_cycle();
      rs_addr = 5; rs_used = 1;
      @(negedge clk);
      checks++; if ({store_fwd, stage_en} !== 6'b0_11100) begin
         errors++; $display("FAIL sw_rs_stall got=%b exp=011100", {store_fwd, stage_en}); end
      next_cycle();
      idle();
   endtask

   task automatic test_branch();
      logic [5:0] fl, rq, ak;
      logic [4:0] een, ers;
      id_is_branch = 1;
      fl = 6'b000111;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         ers = fl[k] ? 5'b00010 : 5'b00000;
         checks++; if ({id_flush, stage_rst} !== {fl[k], ers}) begin
            errors++; $display("FAIL br_plain k=%0d got=%b exp=%b", k, {id_flush, stage_rst}, {fl[k], ers}); end
         next_cycle();
         id_is_branch = 0;
      end
      fl = 6'b011111; rq = 6'b001110; ak = 6'b001000;
      id_is_branch = 1;
      for (int k = 0; k < 6; k++) begin
         mem_req = rq[k]; mem_ack = ak[k];
         @(negedge clk);
         een = (rq[k] && !ak[k]) ? 5'b10000 : 5'b11111;
         ers = (rq[k] && !ak[k]) ? 5'b10000 : (fl[k] ? 5'b00010 : 5'b00000);
         checks++; if ({id_flush, stage_en, stage_rst} !== {fl[k], een, ers}) begin
            errors++; $display("FAIL br_memstall k=%0d got=%b exp=%b", k, {id_flush, stage_en, stage_rst}, {fl[k], een, ers}); end
         next_cycle();
         id_is_branch = 0;
      end
      idle();
   endtask

   task automatic test_mem_wait();
      mem_req = 1;
      for (int k = 0; k < 5; k++) begin
         mem_ack = (k == 4);
         @(negedge clk);
         checks++; if ({stage_en, stage_rst} !== ((k < 4) ? 10'b10000_10000 : 10'b11111_00000)) begin
            errors++; $display("FAIL memwait k=%0d got=%b", k, {stage_en, stage_rst}); end
         next_cycle();
      end
      mem_req = 1; mem_ack = 1;
      @(negedge clk);
      checks++; if (stage_en !== 5'b11111) begin errors++; $display("FAIL mem_sameack got=%b exp=11111", stage_en); end
      next_cycle();
      mem_ack = 0;
      @(negedge clk);
      checks++; if (stage_en !== 5'b10000) begin errors++; $display("FAIL mem_newreq got=%b exp=10000", stage_en); end
      next_cycle();
      mem_ack = 1;
      next_cycle();
      idle();
   endtask

   task automatic test_debug();
      logic [3:0] st, hold;
      st = 4'b0110; hold = 4'b1101;
      debug_en = 1;
      for (int k = 0; k < 4; k++) begin
         debug_step = st[k];
         @(negedge clk);
         checks++; if (stage_en !== (hold[k] ? 5'b00000 : 5'b11111)) begin
            errors++; $display("FAIL dbg k=%0d got=%b", k, stage_en); end
         next_cycle();
      end
      stg_wen = 2'b01; stg_load = 2'b01; stg_waddr = {5'd0, 5'd7}; rs_addr = 7; rs_used = 1;
      @(negedge clk);
      checks++; if ({stage_en, stage_rst} !== 10'b0) begin
         errors++; $display("FAIL dbg_over_load got=%b exp=0000000000", {stage_en, stage_rst}); end
      next_cycle();
      idle();
   endtask

   task automatic test_mem_timeout();
      mem_req = 1;
      for (int k = 0; k < 19; k++) begin
         if (k == 17) mem_req = 0;
         @(negedge clk);
         checks++; if ({mem_err, stage_en} !== ((k >= 16) ? 6'b1_00000 : 6'b0_10000)) begin
            errors++; $display("FAIL timeout k=%0d got=%b", k, {mem_err, stage_en}); end
         next_cycle();
      end
      rst = 0;
      #2;
      checks++; if ({mem_err, stage_en} !== 6'b0_11111) begin
         errors++; $display("FAIL err_clear got=%b exp=011111", {mem_err, stage_en}); end
      next_cycle();
      rst = 1;
      @(negedge clk);
      checks++; if ({mem_err, stage_en} !== 6'b0_11111) begin
         errors++; $display("FAIL err_after_rst got=%b exp=011111", {mem_err, stage_en}); end
      next_cycle();
   endtask

   task automatic test_random();
      exp_t e;
      for (int c = 0; c < 800; c++) begin
         rst          = (c % 200 != 199);
         rs_addr      = REG_AW'($urandom_range(0, 3));
         rt_addr      = REG_AW'($urandom_range(0, 3));
         rs_used      = ($urandom_range(0, 3) != 0);
         rt_used      = ($urandom_range(0, 3) != 0);
         id_is_store  = ($urandom_range(0, 3) == 0);
         id_is_branch = ($urandom_range(0, 4) == 0);
         stg_waddr    = {REG_AW'($urandom_range(0, 3)), REG_AW'($urandom_range(0, 3))};
         stg_wen      = FD'($urandom_range(0, 3));
         stg_load     = FD'($urandom_range(0, 3));
         mem_req      = ($urandom_range(0, 3) == 0);
         mem_ack      = ($urandom_range(0, 2) == 0);
         debug_en     = ($urandom_range(0, 7) == 0);
         debug_step   = 1'($urandom_range(0, 1));
         @(negedge clk);
         e = model_exp();
         checks++; if ({stage_en, stage_rst, id_flush, mem_err, store_fwd} !== {e.en, e.rs, e.flush, e.err, e.sfwd}) begin
            errors++; $display("FAIL rnd_ctrl c=%0d got=%b exp=%b", c,
               {stage_en, stage_rst, id_flush, mem_err, store_fwd}, {e.en, e.rs, e.flush, e.err, e.sfwd}); end
         if (!e.stall) begin
            checks++; if (fwd_a_sel !== e.sel_a) begin
               errors++; $display("FAIL rnd_fwd_a c=%0d got=%0d exp=%0d", c, fwd_a_sel, e.sel_a); end
         end
         if (!e.stall && !e.sfwd) begin
            checks++; if (fwd_b_sel !== e.sel_b) begin
               errors++; $display("FAIL rnd_fwd_b c=%0d got=%0d exp=%0d", c, fwd_b_sel, e.sel_b); end
         end
         next_cycle();
      end
      rst = 1;
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      idle();
      rst = 0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_debug();
      test_mem_timeout();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
